// File: rtl/rvv_backend_xrf_wb_buf_if.sv
// Retire-to-scalar XRF write-back bundle: multi-port retire writes in, one scalar
// register write out, plus the occupancy count.
interface rvv_backend_xrf_wb_buf_if #(
    parameter int NUM_RT_UOP = 4,
    parameter int XLEN       = 32,
    parameter int IDX_W      = 5,
    parameter int CNT_W      = 4
);
    logic [NUM_RT_UOP-1:0]            wr_valid;
    logic [NUM_RT_UOP-1:0][XLEN-1:0]  wr_data;
    logic [NUM_RT_UOP-1:0][IDX_W-1:0] wr_index;
    logic [NUM_RT_UOP-1:0]            wr_ready;
    logic                             xrf_valid;
    logic [XLEN-1:0]                  xrf_data;
    logic [IDX_W-1:0]                 xrf_index;
    logic                             xrf_ready;
    logic [CNT_W-1:0]                 count;

    modport master (
        output wr_valid, wr_data, wr_index, xrf_ready,
        input  wr_ready, xrf_valid, xrf_data, xrf_index, count
    );

    modport slave (
        input  wr_valid, wr_data, wr_index, xrf_ready,
        output wr_ready, xrf_valid, xrf_data, xrf_index, count
    );
endinterface

// File: rtl/rvv_backend_xrf_wb_buf.sv
// In-order write-back FIFO: compacts up to NUM_RT_UOP retire writes per cycle, drains one
// per cycle to the scalar XRF port. Define XRF_WB_BYPASS_EN for same-cycle empty bypass.
module rvv_backend_xrf_wb_buf #(
    parameter int DEPTH      = 8,
    parameter int NUM_RT_UOP = 4,
    parameter int XLEN       = 32,
    parameter int IDX_W      = 5,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    rvv_backend_xrf_wb_buf_if.slave        bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = XLEN + IDX_W;

    logic [ENT_W-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [CNT_W-1:0]      w_free;
    logic [NUM_RT_UOP-1:0] w_wr_ready;
    logic [NUM_RT_UOP-1:0] w_push;
    logic [NUM_RT_UOP-1:0] w_store;
    logic [CNT_W-1:0]      w_prefix [NUM_RT_UOP+1];
    logic [CNT_W-1:0]      w_store_cnt;
    logic [PTR_W-1:0]      w_slot [NUM_RT_UOP];
    logic                  w_fifo_pop;
    logic                  w_byp_valid;
    logic                  w_bypass_take;
    logic [ENT_W-1:0]      w_byp_entry;
    logic [ENT_W-1:0]      w_out_entry;
    logic                  w_out_valid;

    // Ready looks only at registered occupancy so it never depends on this cycle's pop.
    assign w_free = CNT_W'(DEPTH) - r_count;

    generate
        for (genvar gi = 0; gi < NUM_RT_UOP; gi++) begin : g_port
            assign w_wr_ready[gi] = (w_free > CNT_W'(gi));
            assign w_push[gi]     = bus.wr_valid[gi] & w_wr_ready[gi];
            assign w_slot[gi]     = r_wr_ptr + PTR_W'(w_prefix[gi]) - PTR_W'(w_bypass_take);
        end
    endgenerate

`ifdef XRF_WB_BYPASS_EN
    assign w_byp_valid   = (r_count == '0) && (|w_push);
    assign w_bypass_take = w_byp_valid && bus.xrf_ready;

    always_comb begin
        w_byp_entry = '0;
        for (int p = NUM_RT_UOP - 1; p >= 0; p--) begin
            if (w_push[p]) begin
                w_byp_entry = {bus.wr_index[p], bus.wr_data[p]};
            end
        end
    end
`else
    assign w_byp_valid   = 1'b0;
    assign w_bypass_take = 1'b0;
    assign w_byp_entry   = '0;
`endif

    // Prefix popcount gives each accepted port its compacted offset from wr_ptr.
    always_comb begin
        w_prefix[0] = '0;
        w_store     = '0;
        for (int p = 0; p < NUM_RT_UOP; p++) begin
            w_prefix[p+1] = w_prefix[p] + CNT_W'(w_push[p]);
            w_store[p]    = w_push[p] && !(w_bypass_take && (w_prefix[p] == '0));
        end
        w_store_cnt = w_prefix[NUM_RT_UOP] - CNT_W'(w_bypass_take);
    end

    assign w_fifo_pop = (r_count != '0) && bus.xrf_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_store_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_fifo_pop);
            r_count  <= r_count + w_store_cnt - CNT_W'(w_fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_RT_UOP; p++) begin
            if (w_store[p]) begin
                r_mem[w_slot[p]] <= {bus.wr_index[p], bus.wr_data[p]};
            end
        end
    end

    always_comb begin
        w_out_valid = 1'b0;
        w_out_entry = '0;
        if (r_count != '0) begin
            w_out_valid = 1'b1;
            w_out_entry = r_mem[r_rd_ptr];
        end else if (w_byp_valid) begin
            w_out_valid = 1'b1;
            w_out_entry = w_byp_entry;
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.xrf_valid = w_out_valid;
    assign bus.xrf_index = w_out_entry[ENT_W-1:XLEN];
    assign bus.xrf_data  = w_out_entry[XLEN-1:0];
    assign bus.count     = r_count;

endmodule

// File: tb/tb_rvv_backend_xrf_wb_buf.sv
// Directed bench for rvv_backend_xrf_wb_buf: ordering, compaction, full, wrap,
// backpressure, asynchronous reset and the optional empty bypass.
module tb_rvv_backend_xrf_wb_buf;
    localparam int N     = 4;
    localparam int XL    = 32;
    localparam int IW    = 5;
    localparam int CW    = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rvv_backend_xrf_wb_buf_if #(.NUM_RT_UOP(N), .XLEN(XL), .IDX_W(IW), .CNT_W(CW)) bus ();

    rvv_backend_xrf_wb_buf #(
        .DEPTH(DEPTH), .NUM_RT_UOP(N), .XLEN(XL), .IDX_W(IW), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [4:0] idx);
        return 32'hDA7A_0000 | (32'(idx) << 8) | 32'(idx);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] idx,
                           input logic [3:0] cnt);
        chk({tag, ".valid"}, 32'(bus.xrf_valid), 32'(v));
        chk({tag, ".index"}, 32'(bus.xrf_index), v ? 32'(idx) : 32'h0);
        chk({tag, ".data"},  bus.xrf_data,       v ? dat(idx) : 32'h0);
        chk({tag, ".count"}, 32'(bus.count),     32'(cnt));
    endtask

    task automatic drive(input logic [3:0] v, input logic [4:0] i0, input logic [4:0] i1,
                         input logic [4:0] i2, input logic [4:0] i3, input logic xr);
        bus.wr_valid    = v;
        bus.wr_index[0] = i0; bus.wr_data[0] = dat(i0);
        bus.wr_index[1] = i1; bus.wr_data[1] = dat(i1);
        bus.wr_index[2] = i2; bus.wr_data[2] = dat(i2);
        bus.wr_index[3] = i3; bus.wr_data[3] = dat(i3);
        bus.xrf_ready   = xr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #4;
    endtask

    // Occupancy must stay within 0..DEPTH; an underflow wraps above DEPTH.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (bus.count <= 4'(DEPTH)) else begin
                errors++;
                $error("FAIL count_bound: observed=%0d expected<=%0d", bus.count, DEPTH);
            end
        end
    end

    initial begin
        drive(4'b0000, 0, 0, 0, 0, 1'b0);
        #7;
        chk_out("reset", 1'b0, 0, 0);
        chk("reset.wr_ready", 32'(bus.wr_ready), 32'hF);
        #5;
        rst = 1'b0;

        // Four pushes into an empty FIFO with the scalar port ready
        tick(); drive(4'b1111, 1, 2, 3, 4, 1'b1); settle();
        chk("t1.wr_ready", 32'(bus.wr_ready), 32'hF);
`ifdef XRF_WB_BYPASS_EN
        chk_out("t1.bypass", 1'b1, 1, 0);
        for (int k = 1; k < 4; k++) begin
            tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1); settle();
            chk_out("t1.drain", 1'b1, 5'(k + 1), 4'(4 - k));
        end
`else
        chk_out("t1.latency", 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1); settle();
            chk_out("t1.drain", 1'b1, 5'(k + 1), 4'(4 - k));
        end
`endif
        tick(); settle();
        chk_out("t1.empty", 1'b0, 0, 0);

        // Non-contiguous valids 1010 compact to port1 then port3
        tick(); drive(4'b1010, 0, 7, 0, 9, 1'b0); settle();
        chk("t3.wr_ready", 32'(bus.wr_ready), 32'hF);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1); settle();
        chk_out("t3.first", 1'b1, 7, 2);
        tick(); settle();
        chk_out("t3.second", 1'b1, 9, 1);
        tick(); settle();
        chk_out("t3.empty", 1'b0, 0, 0);

        // Backpressure: head stays stable for five stalled cycles
        tick(); drive(4'b0111, 5, 6, 8, 0, 1'b0);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            settle(); chk_out("bp.hold", 1'b1, 5, 3);
            tick();
        end
        drive(4'b0000, 0, 0, 0, 0, 1'b1); settle();
        chk_out("bp.release", 1'b1, 5, 3);
        tick(); settle(); chk_out("bp.drain1", 1'b1, 6, 2);
        tick(); settle(); chk_out("bp.drain2", 1'b1, 8, 1);
        tick(); settle(); chk_out("bp.empty", 1'b0, 0, 0);

        // Asynchronous reset between edges with five entries held
        tick(); drive(4'b1111, 1, 2, 3, 4, 1'b0);
        tick(); drive(4'b0001, 5, 0, 0, 0, 1'b0);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b0); settle();
        chk_out("rst.before", 1'b1, 1, 5);
        rst = 1'b1;
        #1;
        chk_out("rst.async", 1'b0, 0, 0);
        #2;
        rst = 1'b0;
        tick(); settle();
        chk_out("rst.after", 1'b0, 0, 0);
        chk("rst.wr_ready", 32'(bus.wr_ready), 32'hF);

        // Fill to six, partial accept to full, then full with a simultaneous pop
        tick(); drive(4'b1111, 10, 11, 12, 13, 1'b0);
        tick(); drive(4'b0011, 14, 15, 0, 0, 1'b0);
        tick(); drive(4'b1111, 16, 17, 18, 19, 1'b0); settle();
        chk("full.ready_at6", 32'(bus.wr_ready), 32'b0011);
        tick(); drive(4'b1111, 20, 21, 22, 23, 1'b1); settle();
        chk("full.ready_at8", 32'(bus.wr_ready), 32'b0000);
        chk_out("full.8", 1'b1, 10, 8);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1); settle();
        chk("full.ready_after_pop", 32'(bus.wr_ready), 32'b0001);
        chk_out("full.7", 1'b1, 11, 7);
        for (int k = 12; k <= 17; k++) begin
            tick(); settle();
            chk_out("full.drain", 1'b1, 5'(k), 4'(18 - k));
        end
        tick(); settle();
        chk_out("full.empty", 1'b0, 0, 0);

        // Move pointers to 6, then push four entries across the wrap
        tick(); drive(4'b1111, 1, 2, 3, 4, 1'b0);
        tick(); drive(4'b0011, 5, 6, 0, 0, 1'b0);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            settle(); chk_out("wrap.pre", 1'b1, 5'(k + 1), 4'(6 - k));
            tick();
        end
        drive(4'b1111, 20, 21, 22, 23, 1'b0);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            settle(); chk_out("wrap.drain", 1'b1, 5'(20 + k), 4'(4 - k));
            tick();
        end
        settle();
        chk_out("wrap.empty", 1'b0, 0, 0);

        // Single push on port0 into an empty FIFO with the scalar port ready
        tick(); drive(4'b0001, 12, 0, 0, 0, 1'b1); settle();
`ifdef XRF_WB_BYPASS_EN
        chk_out("byp.same", 1'b1, 12, 0);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1); settle();
        chk_out("byp.after", 1'b0, 0, 0);
`else
        chk_out("byp.none", 1'b0, 0, 0);
        tick(); drive(4'b0000, 0, 0, 0, 0, 1'b1); settle();
        chk_out("byp.next", 1'b1, 12, 1);
        tick(); settle();
        chk_out("byp.empty", 1'b0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
